// File: rtl/icache_ro.sv
// -----------------------------------------------------------------------------
// icache_ro
// Read-only, direct-mapped instruction cache. It answers the processor-side
// ICACHE port driven by the instruction realigner. On a miss it fetches one
// whole 128-bit line from instruction memory. Hits return data in the same
// cycle as the request.
//
// Parameters
//   IDX_W  line index width; the cache holds 2^IDX_W lines
//   TAG_W  tag width; must equal 28 - IDX_W
//
// Ports
//   clk, rst     clock (rising edge) and asynchronous active-high reset
//   proc_read    read request, sampled every cycle
//   proc_write   write request; the cache is read-only, so this is ignored
//   proc_addr    word address {tag, index, word offset[1:0]}
//   proc_wdata   ignored
//   proc_rdata   addressed word of the indexed line (combinational)
//   proc_stall   request cannot be served this cycle (combinational)
//   mem_read     registered line-fill request to memory
//   mem_write    tied low
//   mem_addr     registered line address {tag, index}
//   mem_wdata    tied low
//   mem_rdata    returned line; word k sits in bits [32k+31:32k]
//   mem_ready    one-cycle pulse; mem_rdata is valid in that same cycle
//   miss_count   saturating count of line fills started
// -----------------------------------------------------------------------------
module icache_ro #(
   parameter int IDX_W = 3,
   parameter int TAG_W = 25
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          proc_read,
   input  logic          proc_write,
   input  logic [29:0]   proc_addr,
   input  logic [31:0]   proc_wdata,
   output logic [31:0]   proc_rdata,
   output logic          proc_stall,
   output logic          mem_read,
   output logic          mem_write,
   output logic [27:0]   mem_addr,
   output logic [127:0]  mem_wdata,
   input  logic [127:0]  mem_rdata,
   input  logic          mem_ready,
   output logic [15:0]   miss_count
);

   localparam int LINES = 1 << IDX_W;

   typedef enum logic {
      IDLE  = 1'b0,
      FETCH = 1'b1
   } state_t;

   state_t state, state_nx;

   // Line storage
   logic [LINES-1:0] valid;
   logic [TAG_W-1:0] tag_arr  [LINES];
   logic [127:0]     data_arr [LINES];

   // Request address fields
   logic [1:0]       req_off;
   logic [IDX_W-1:0] req_idx;
   logic [TAG_W-1:0] req_tag;

   // Latched fill target, split back into its index and tag
   logic [IDX_W-1:0] fill_idx;
   logic [TAG_W-1:0] fill_tag;

   logic hit;
   logic start_miss;
   logic fill_done;

   // The cache never writes; these inputs are intentionally left unused.
   logic unused_inputs;
   assign unused_inputs = ^{proc_write, proc_wdata};

   assign mem_write = 1'b0;
   assign mem_wdata = '0;

   assign req_off  = proc_addr[1:0];
   assign req_idx  = proc_addr[IDX_W+1:2];
   assign req_tag  = proc_addr[29:IDX_W+2];

   assign fill_idx = mem_addr[IDX_W-1:0];
   assign fill_tag = mem_addr[27:IDX_W];

   // Lookup and word select. The word is driven whether or not the line hits;
   // the realigner only consumes it when proc_stall is low.
   assign hit        = valid[req_idx] && (tag_arr[req_idx] == req_tag);
   assign proc_rdata = data_arr[req_idx][{req_off, 5'd0} +: 32];

   // Next-state and control decode
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path
      // through the case statement can leave a value held (no latch).
      state_nx   = state;
      proc_stall = 1'b0;
      start_miss = 1'b0;
      fill_done  = 1'b0;

      case (state)
         IDLE: begin
            if (proc_read && !hit) begin
               proc_stall = 1'b1;
               start_miss = 1'b1;
               state_nx   = FETCH;
            end
         end

         FETCH: begin
            // The fill always runs to completion against the latched
            // mem_addr, even if the processor has moved on or dropped
            // its request.
            proc_stall = 1'b1;
            if (mem_ready) begin
               fill_done = 1'b1;
               state_nx  = IDLE;
            end
         end

         default: state_nx = IDLE;
      endcase
   end

   // Control state: FSM, valid bits, memory request and miss counter
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         valid      <= '0;
         mem_read   <= 1'b0;
         mem_addr   <= '0;
         miss_count <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every
         // flop samples the pre-edge values regardless of statement order.
         state <= state_nx;

         if (start_miss) begin
            mem_read <= 1'b1;
            mem_addr <= {req_tag, req_idx};
            if (miss_count != 16'hFFFF) begin
               miss_count <= miss_count + 16'd1;
            end
         end

         if (fill_done) begin
            mem_read        <= 1'b0;
            valid[fill_idx] <= 1'b1;
         end
      end
   end

   // Tag and data arrays
   // NOTE: the arrays carry no reset; clearing the valid bits is enough to
   // make their contents unobservable, and it keeps them mappable to RAM.
   always_ff @(posedge clk) begin
      if (fill_done) begin
         tag_arr[fill_idx]  <= fill_tag;
         data_arr[fill_idx] <= mem_rdata;
      end
   end

endmodule

// File: tb/tb_icache_ro.sv
// -----------------------------------------------------------------------------
// tb_icache_ro
// Directed bench for icache_ro. Inputs change on the falling clock edge and
// outputs are sampled 1 time unit later, well away from the rising edge.
// -----------------------------------------------------------------------------
module tb_icache_ro;

   logic         clk = 1'b0;
   logic         rst;
   logic         proc_read;
   logic         proc_write;
   logic [29:0]  proc_addr;
   logic [31:0]  proc_wdata;
   logic [31:0]  proc_rdata;
   logic         proc_stall;
   logic         mem_read;
   logic         mem_write;
   logic [27:0]  mem_addr;
   logic [127:0] mem_wdata;
   logic [127:0] mem_rdata;
   logic         mem_ready;
   logic [15:0]  miss_count;

   int n_cmp  = 0;
   int n_fail = 0;

   localparam logic [127:0] LINE_A = 128'hDDDD_DDDD_CCCC_CCCC_BBBB_BBBB_AAAA_AAAA;
   localparam logic [127:0] LINE_B = 128'h4444_4444_3333_3333_2222_2222_1111_1111;
   localparam logic [127:0] LINE_C = 128'h8888_8888_7777_7777_6666_6666_5555_5555;
   localparam logic [127:0] JUNK   = 128'hDEAD_BEEF_DEAD_BEEF_DEAD_BEEF_DEAD_BEEF;

   icache_ro #(.IDX_W(3), .TAG_W(25)) dut (
      .clk        (clk),
      .rst        (rst),
      .proc_read  (proc_read),
      .proc_write (proc_write),
      .proc_addr  (proc_addr),
      .proc_wdata (proc_wdata),
      .proc_rdata (proc_rdata),
      .proc_stall (proc_stall),
      .mem_read   (mem_read),
      .mem_write  (mem_write),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata),
      .mem_ready  (mem_ready),
      .miss_count (miss_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [127:0] obs,
                        input logic [127:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Wait for the next falling edge, apply one cycle of inputs, then settle.
   task automatic cyc(input logic rd, input logic wr, input logic [29:0] addr,
                      input logic rdy, input logic [127:0] line);
      @(negedge clk);
      proc_read  = rd;
      proc_write = wr;
      proc_addr  = addr;
      proc_wdata = wr ? 32'hFFFF_FFFF : 32'h0;
      mem_ready  = rdy;
      mem_rdata  = line;
      #1;
   endtask

   initial begin
      rst        = 1'b1;
      proc_read  = 1'b0;
      proc_write = 1'b0;
      proc_addr  = '0;
      proc_wdata = '0;
      mem_ready  = 1'b0;
      mem_rdata  = '0;

      // ---------------- Reset values ----------------
      #12;
      check("rst_mem_read",   mem_read,   0);
      check("rst_mem_addr",   mem_addr,   0);
      check("rst_miss_count", miss_count, 0);
      check("rst_mem_write",  mem_write,  0);
      check("rst_mem_wdata",  mem_wdata,  0);
      check("rst_stall_idle", proc_stall, 0);
      proc_read = 1'b1;
      proc_addr = 30'h5;
      #1;
      check("rst_stall_read", proc_stall, 1);

      // ---------------- Cold miss at 0x5, memory answers 3 cycles later ----
      cyc(1, 0, 30'h5, 0, '0);                 // T: release reset
      rst = 1'b0;
      #1;
      check("cold_T_stall",    proc_stall, 1);
      check("cold_T_mem_read", mem_read,   0);
      cyc(1, 0, 30'h5, 0, '0);                 // T+1
      check("cold_T1_mem_read", mem_read,   1);
      check("cold_T1_mem_addr", mem_addr,   28'h1);
      check("cold_T1_stall",    proc_stall, 1);
      check("cold_T1_misses",   miss_count, 1);
      cyc(1, 0, 30'h5, 0, '0);                 // T+2
      check("cold_T2_stall",    proc_stall, 1);
      check("cold_T2_mem_read", mem_read,   1);
      cyc(1, 0, 30'h5, 1, LINE_A);             // T+3 = M
      check("cold_M_stall",     proc_stall, 1);
      cyc(1, 0, 30'h5, 0, '0);                 // M+1
      check("cold_M1_stall",    proc_stall, 0);
      check("cold_M1_rdata",    proc_rdata, 32'hBBBB_BBBB);
      check("cold_M1_misses",   miss_count, 1);
      check("cold_M1_mem_read", mem_read,   0);

      // ---------------- Line reuse sweep ----------------
      cyc(1, 0, 30'h4, 0, '0);
      check("reuse4_stall", proc_stall, 0);
      check("reuse4_rdata", proc_rdata, 32'hAAAA_AAAA);
      cyc(1, 0, 30'h5, 0, '0);
      check("reuse5_stall", proc_stall, 0);
      check("reuse5_rdata", proc_rdata, 32'hBBBB_BBBB);
      cyc(1, 0, 30'h6, 0, '0);
      check("reuse6_stall", proc_stall, 0);
      check("reuse6_rdata", proc_rdata, 32'hCCCC_CCCC);
      cyc(1, 0, 30'h7, 0, '0);
      check("reuse7_stall", proc_stall, 0);
      check("reuse7_rdata", proc_rdata, 32'hDDDD_DDDD);
      check("reuse_mem_read", mem_read,   0);
      check("reuse_misses",   miss_count, 1);

      // ---------------- Conflict eviction on index 1 ----------------
      cyc(1, 0, 30'h04, 0, '0);
      check("conf04_hit", proc_stall, 0);
      cyc(1, 0, 30'h24, 0, '0);
      check("conf24_stall", proc_stall, 1);
      cyc(1, 0, 30'h24, 1, LINE_B);            // minimum penalty: ready in T+1
      check("conf24_mem_read", mem_read,   1);
      check("conf24_mem_addr", mem_addr,   28'h9);
      check("conf24_stall_M",  proc_stall, 1);
      check("conf24_misses",   miss_count, 2);
      cyc(1, 0, 30'h24, 0, '0);
      check("conf24_hit",   proc_stall, 0);
      check("conf24_rdata", proc_rdata, 32'h1111_1111);
      cyc(1, 0, 30'h04, 0, '0);
      check("conf04_again_stall", proc_stall, 1);

      // ---------------- Flush mid-fill ----------------
      // FETCH for line 0x1 is running; the processor drops its read and
      // branches to 0x40 in the same cycle memory answers.
      cyc(0, 0, 30'h40, 1, LINE_A);
      check("flush_mem_addr", mem_addr,   28'h1);
      check("flush_misses",   miss_count, 3);
      check("flush_stall",    proc_stall, 1);
      cyc(1, 0, 30'h40, 0, '0);
      check("flush40_stall", proc_stall, 1);
      check("flush40_idle",  mem_read,   0);
      cyc(1, 0, 30'h40, 1, LINE_C);
      check("flush40_mem_read", mem_read,   1);
      check("flush40_mem_addr", mem_addr,   28'h10);
      check("flush40_misses",   miss_count, 4);
      cyc(1, 0, 30'h40, 0, '0);
      check("flush40_hit",   proc_stall, 0);
      check("flush40_rdata", proc_rdata, 32'h5555_5555);
      cyc(1, 0, 30'h05, 0, '0);                // line 0x1 fill did complete
      check("flush05_hit",   proc_stall, 0);
      check("flush05_rdata", proc_rdata, 32'hBBBB_BBBB);

      // ---------------- Spurious inputs while IDLE ----------------
      cyc(1, 1, 30'h05, 1, JUNK);
      check("spur_stall",    proc_stall, 0);
      check("spur_rdata",    proc_rdata, 32'hBBBB_BBBB);
      check("spur_mem_read", mem_read,   0);
      cyc(1, 0, 30'h05, 0, '0);
      check("spur_after_stall",    proc_stall, 0);
      check("spur_after_rdata",    proc_rdata, 32'hBBBB_BBBB);
      check("spur_after_mem_read", mem_read,   0);
      check("spur_after_misses",   miss_count, 4);
      cyc(0, 1, 30'h24, 0, '0);                // write-only to a missing line
      check("wronly_stall", proc_stall, 0);
      cyc(0, 0, 30'h24, 0, '0);
      check("wronly_mem_read", mem_read, 0);

      // ---------------- Reset mid-FETCH ----------------
      cyc(1, 0, 30'h24, 0, '0);
      check("rstf_stall", proc_stall, 1);
      cyc(1, 0, 30'h24, 0, '0);
      check("rstf_mem_read", mem_read,   1);
      check("rstf_mem_addr", mem_addr,   28'h9);
      check("rstf_misses",   miss_count, 5);
      rst = 1'b1;
      #1;
      check("rstf_async_mem_read", mem_read,   0);
      check("rstf_async_mem_addr", mem_addr,   0);
      check("rstf_async_misses",   miss_count, 0);
      check("rstf_async_stall",    proc_stall, 1);
      cyc(0, 0, 30'h24, 0, '0);
      rst = 1'b0;
      cyc(0, 0, 30'h24, 1, LINE_B);            // late mem_ready, must be ignored
      check("rstf_late_ready_mem_read", mem_read, 0);
      cyc(1, 0, 30'h24, 0, '0);
      check("rstf_rereq_stall", proc_stall, 1);
      cyc(0, 0, 30'h24, 0, '0);
      check("rstf_rereq_mem_read", mem_read,   1);
      check("rstf_rereq_mem_addr", mem_addr,   28'h9);
      check("rstf_rereq_misses",   miss_count, 1);
      cyc(0, 0, 30'h24, 1, LINE_B);
      cyc(1, 0, 30'h05, 0, '0);                // line 0x1 was invalidated too
      check("rstf_old_line_stall", proc_stall, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   // Absolute bound so the run always terminates.
   initial begin
      #100000;
      $display("FAIL timeout: simulation did not reach the summary");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/icache_ro.md
Name: icache_ro

Overview:
- Read-only, direct-mapped instruction cache.
- Acts as the responder on the processor-side ICACHE port (ren/wen/addr/wdata/rdata/stall) driven by the instruction realigner.
- On a miss it fills one whole line from instruction memory over a 128-bit line interface.
- Hits return data combinationally in the request cycle.

Parameters:
- IDX_W, 3, line index width; number of lines = 2^IDX_W.
- TAG_W, 25, tag width; must equal 28 - IDX_W.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- proc_read  input  1  read request; sampled every cycle.
- proc_write  input  1  write request; unsupported, ignored.
- proc_addr  input  30  word address {tag, index, word offset[1:0]}.
- proc_wdata  input  32  unused; ignored.
- proc_rdata  output  32  selected word of the addressed line; combinational.
- proc_stall  output  1  high while the request cannot be served this cycle; combinational.
- mem_read  output  1  line-fill request to memory; registered.
- mem_write  output  1  tied 0.
- mem_addr  output  28  line address {tag, index}; registered.
- mem_wdata  output  128  tied 0.
- mem_rdata  input  128  line data; word k occupies bits [32k+31:32k].
- mem_ready  input  1  one-cycle pulse; mem_rdata is valid in the same cycle.
- miss_count  output  16  saturating count of line fills started.

Behaviour:
- Address split:
  - offset = proc_addr[1:0].
  - index = proc_addr[IDX_W+1:2].
  - tag = proc_addr[29:IDX_W+2].
- Storage per line: valid bit, TAG_W tag, 128-bit data.
- hit = valid[index] and tag[index] == tag.
- proc_rdata = data[index] word offset, regardless of hit. It is don't-care when proc_stall=1 or proc_read=0.
- FSM states: IDLE, FETCH.
- IDLE:
  - proc_stall = proc_read & ~hit.
  - On proc_read & ~hit: next state FETCH, mem_read<=1, mem_addr<={tag, index}, miss_count increments (holds at 16'hFFFF).
  - Otherwise hold.
- FETCH:
  - proc_stall = 1, independent of proc_read.
  - mem_read and mem_addr hold until mem_ready.
  - On mem_ready:
    - data[mem_addr index]<=mem_rdata, tag<=mem_addr tag, valid<=1.
    - mem_read<=0; next state IDLE.
- Miss timing:
  - Request cycle T: stall=1.
  - mem_read rises at T+1.
  - mem_ready at cycle M: line written at the edge ending M; stall stays 1 in M.
  - M+1: IDLE re-lookup hits, stall=0, data valid.
  - Minimum miss penalty is 2 cycles (mem_ready in T+1).
- Address change during FETCH (branch/flush): the fill always completes to the latched mem_addr. In the cycle after, IDLE re-evaluates the current proc_addr and may start a new miss.
- proc_read dropped during FETCH: the fill still completes; no new request is issued.
- mem_ready while IDLE: ignored; no state or array change.
- proc_write=1: no effect on arrays or FSM; proc_stall follows proc_read only.
- Simultaneous proc_read and proc_write: treated as a read.
- Reset, asynchronous, any time including mid-FETCH:
  - State IDLE, all valid=0.
  - mem_read=0, mem_addr=0, miss_count=0.
  - Tag and data arrays are not required to reset.
  - A mem_ready pulse arriving after reset is ignored.
- Values during and immediately after reset:
  - proc_stall = proc_read (all lines invalid).
  - mem_write=0, mem_wdata=0.
  - proc_rdata undefined-but-stable (don't-care).

Test Plan:
- Cold miss: reset, proc_read=1, proc_addr=30'h0000_0005; memory returns 128'hDDDD_DDDD_CCCC_CCCC_BBBB_BBBB_AAAA_AAAA after 3 cycles.
  - Required: mem_read=1 with mem_addr=28'h1; stall high through the mem_ready cycle.
  - Next cycle: stall=0, proc_rdata=32'hBBBB_BBBB; miss_count=1.
- Line reuse: after the fill, sweep addr 0x4, 0x5, 0x6, 0x7 -> stall=0 every cycle; words AAAA.., BBBB.., CCCC.., DDDD..; no mem_read; miss_count stays 1.
- Conflict eviction (IDX_W=3): read addr 0x04, then 0x24 (same index 1, different tag).
  - Required: second access misses with mem_addr=28'h9.
  - Re-read 0x04 -> misses again; miss_count=3.
- Flush mid-fill: during FETCH for 0x04, drop proc_read and change proc_addr to 0x40.
  - Required: fill of line 0x1 completes.
  - Next cycle with proc_read=1 @0x40 -> new miss, mem_addr=28'h10.
- Reset mid-FETCH: assert rst while mem_read=1, then pulse mem_ready after release.
  - Required: mem_read=0 immediately; line not valid; proc_stall=1 on re-request of the same address.
- Spurious inputs in IDLE: pulse mem_ready and proc_write=1 with proc_wdata=32'hFFFF_FFFF on a hit address.
  - Required: proc_rdata unchanged, proc_stall=0, no mem_read.
